// File: rtl/spi_bus_sched_pkg.sv
// Shared constants and types for the SPI bus scheduler and its clients.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_bus_sched_pkg;

    // Slave-select indices, also used by the command handler to address pots/EEPROM
    localparam int SS_CH1  = 0;
    localparam int SS_CH2  = 1;
    localparam int SS_CH3  = 2;
    localparam int SS_TRIG = 3;
    localparam int SS_EEP  = 4;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_NUM_SS  = 5;
    localparam int DEF_SS_GAP  = 4;

    localparam int CMD_W    = 16;
    localparam int SS_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP
    } spi_sched_state_t;

endpackage

// File: rtl/spi_bus_sched_if.sv
// Bundles the requester-side and spi_mstr-side signals of the SPI bus scheduler.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their done pulse; no other stall path.
interface spi_bus_sched_if
    import spi_bus_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int NUM_SS  = DEF_NUM_SS
);

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*SS_IDX_W-1:0] req_ss;
    logic [NUM_REQ*CMD_W-1:0]    req_cmd;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          done;
    logic                        err;
    logic [CMD_W-1:0]            rd_data;
    logic                        busy;
    logic                        spi_wrt;
    logic [CMD_W-1:0]            spi_cmd;
    logic                        spi_done;
    logic [CMD_W-1:0]            spi_rd;
    logic [NUM_SS-1:0]           ss_n;

    // Scheduler side
    modport slave (
        input  req, req_ss, req_cmd, spi_done, spi_rd,
        output gnt, done, err, rd_data, busy, spi_wrt, spi_cmd, ss_n
    );

    // Requesters plus spi_mstr side
    modport master (
        output req, req_ss, req_cmd, spi_done, spi_rd,
        input  gnt, done, err, rd_data, busy, spi_wrt, spi_cmd, ss_n
    );

endinterface

// File: rtl/spi_bus_sched_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module spi_bus_sched_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               vld
);

    logic [PTR_W-1:0] idx;

    // Scan requesters starting at ptr, wrapping, and keep the first one found
    always_comb begin
        win = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!vld && req[idx]) begin
                win[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_sched.sv
// Shares one spi_mstr among NUM_REQ requesters: round-robin pick, one-hot SS_n, MISO return.
// Latency: req->gnt/spi_wrt 1 cycle; spi_done->done 1 cycle; done->next gnt >= SS_GAP+2 cycles.
// Backpressure: requesters hold req until done; a new launch waits for the SS_n-high gap.
module spi_bus_sched
    import spi_bus_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int NUM_SS  = DEF_NUM_SS,
    parameter int SS_GAP  = DEF_SS_GAP
) (
    input  logic           clk,
    input  logic           rst,
    spi_bus_sched_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(SS_GAP + 1);

    spi_sched_state_t    state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                err_q, err_d;
    logic                wrt_q, wrt_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic [CMD_W-1:0]    rd_q, rd_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    widx_q, widx_d;
    logic                bad_q, bad_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  arb_win;
    logic                arb_vld;
    logic [PTR_W-1:0]    sel_idx;
    logic [CMD_W-1:0]    sel_cmd;
    logic [SS_IDX_W-1:0] sel_ss;
    logic [NUM_SS-1:0]   sel_ss_n;
    logic                sel_ss_ok;

    spi_bus_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .win (arb_win),
        .vld (arb_vld)
    );

    // Pull the winner's index, command word and slave index out of the packed request buses
    always_comb begin
        sel_idx = '0;
        sel_cmd = '0;
        sel_ss  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_win[k]) begin
                sel_idx = PTR_W'(k);
                sel_cmd = bus.req_cmd[CMD_W*k +: CMD_W];
                sel_ss  = bus.req_ss[SS_IDX_W*k +: SS_IDX_W];
            end
        end
    end

    // Decode the winner's slave index into an active-low select; out-of-range leaves all high
    always_comb begin
        sel_ss_ok = (int'(sel_ss) < NUM_SS);
        sel_ss_n  = '1;
        for (int k = 0; k < NUM_SS; k++) begin
            sel_ss_n[k] = (int'(sel_ss) != k);
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        ss_n_d  = ss_n_q;
        rd_d    = rd_q;
        ptr_d   = ptr_q;
        widx_d  = widx_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = LAUNCH;
                    gnt_d   = arb_win;
                    widx_d  = sel_idx;
                    ptr_d   = PTR_W'((int'(sel_idx) + 1) % NUM_REQ);
                    if (sel_ss_ok) begin
                        wrt_d  = 1'b1;
                        cmd_d  = sel_cmd;
                        ss_n_d = sel_ss_n;
                        bad_d  = 1'b0;
                    end else begin
                        // Nothing to talk to: finish the request immediately with err
                        done_d = arb_win;
                        err_d  = 1'b1;
                        bad_d  = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                if (bad_q) begin
                    // The LAUNCH cycle already carried done, so it counts as the first gap cycle
                    state_d = GAP;
                    cnt_d   = CNT_W'(SS_GAP - 1);
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.spi_done) begin
                    done_d[widx_q] = 1'b1;
                    rd_d           = bus.spi_rd;
                    ss_n_d         = '1;
                    state_d        = GAP;
                    cnt_d          = CNT_W'(SS_GAP);
                end
            end
            GAP: begin
                // The done cycle is the first SS_n-high cycle; SS_GAP more follow before IDLE
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset releases every slave select at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= '0;
            ss_n_q  <= '1;
            rd_q    <= '0;
            ptr_q   <= '0;
            widx_q  <= '0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            ss_n_q  <= ss_n_d;
            rd_q    <= rd_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.spi_wrt = wrt_q;
    assign bus.spi_cmd = cmd_q;
    assign bus.ss_n    = ss_n_q;
    assign bus.rd_data = rd_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_bus_sched.sv
// Directed bench for spi_bus_sched with a behavioural spi_mstr (done 40 cycles after wrt, rd=~cmd).
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_bus_sched;
    import spi_bus_sched_pkg::*;

    localparam int NR      = 4;
    localparam int NS      = 5;
    localparam int GAPC    = 4;
    localparam int SPI_LAT = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_bus_sched_if #(.NUM_REQ(NR), .NUM_SS(NS)) bus ();

    spi_bus_sched #(
        .NUM_REQ (NR),
        .NUM_SS  (NS),
        .SS_GAP  (GAPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // spi_mstr model plus an injection path for stray spi_done pulses
    int          mcnt;
    logic        mdone;
    logic [15:0] mcmd, mrd;
    logic        inj_done;
    logic [15:0] inj_rd;

    assign bus.spi_done = mdone | inj_done;
    assign bus.spi_rd   = inj_done ? inj_rd : mrd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt  <= 0;
            mdone <= 1'b0;
            mcmd  <= '0;
            mrd   <= '0;
        end else begin
            mdone <= 1'b0;
            if (bus.spi_wrt) begin
                mcnt <= SPI_LAT - 1;
                mcmd <= bus.spi_cmd;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    mdone <= 1'b1;
                    mrd   <= ~mcmd;
                end
            end
        end
    end

    // Monitors
    int cyc = 0;
    int done_cnt = 0;
    int wrt_cnt = 0;
    int ss_viol = 0;
    int spi_done_cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.done != '0) done_cnt <= done_cnt + 1;
        if (bus.spi_wrt) wrt_cnt <= wrt_cnt + 1;
        if ($countones(~bus.ss_n) > 1) ss_viol <= ss_viol + 1;
        if (bus.spi_done) spi_done_cyc <= cyc;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [2:0] ss, input logic [15:0] cmd);
        bus.req_ss[3*i +: 3]   = ss;
        bus.req_cmd[16*i +: 16] = cmd;
    endtask

    task automatic wait_gnt(input int budget, output int idx, output int c);
        idx = -1;
        c   = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (bus.gnt != '0) begin
                idx = oh_idx(bus.gnt);
                c   = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output logic [NR-1:0] dv, output int c);
        dv = '0;
        c  = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (bus.done != '0) begin
                dv = bus.done;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output int c);
        c = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (!bus.busy) begin
                c = cyc;
                break;
            end
        end
    endtask

    initial begin
        int          idx, cg, cd, ci, c0, prev_done, dc0, wc0;
        logic [NR-1:0] dv;
        logic [15:0] e16;
        int          order   [5] = '{0, 1, 2, 3, 0};
        logic [4:0]  exp_ssn [4] = '{5'b11110, 5'b11101, 5'b10111, 5'b01111};
        logic [15:0] exp_cmd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        bus.req     = '0;
        bus.req_ss  = '0;
        bus.req_cmd = '0;
        inj_done    = 1'b0;
        inj_rd      = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_ss_n", bus.ss_n, 5'h1F);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_spi_wrt", bus.spi_wrt, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_spi_cmd", bus.spi_cmd, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();

        // 1. Single request to CH3
        set_req(0, 3'(SS_CH3), 16'h13A5);
        bus.req[0] = 1'b1;
        c0 = cyc;
        wait_gnt(5, idx, cg);
        chk("t1_gnt_idx", idx, 0);
        chk("t1_gnt_lat", cg - c0, 1);
        chk("t1_spi_wrt", bus.spi_wrt, 1);
        chk("t1_ss_n", bus.ss_n, 5'b11011);
        chk("t1_spi_cmd", bus.spi_cmd, 16'h13A5);
        chk("t1_busy", bus.busy, 1);
        wait_done(60, dv, cd);
        chk("t1_done", dv, 4'b0001);
        chk("t1_done_lat", cd - cg, SPI_LAT + 1);
        chk("t1_done_after_spi_done", cd - spi_done_cyc, 1);
        chk("t1_rd_data", bus.rd_data, 16'hEC5A);
        chk("t1_ss_n_released", bus.ss_n, 5'h1F);
        bus.req[0] = 1'b0;
        wait_idle(20, ci);
        chk("t1_gap_len", ci - cd, GAPC + 1);

        // 2. All four requesting from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_req(0, 3'(SS_CH1), exp_cmd[0]);
        set_req(1, 3'(SS_CH2), exp_cmd[1]);
        set_req(2, 3'(SS_TRIG), exp_cmd[2]);
        set_req(3, 3'(SS_EEP), exp_cmd[3]);
        bus.req = 4'hF;
        prev_done = -1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(80, idx, cg);
            chk($sformatf("t2_order%0d", k), idx, order[k]);
            if (k > 0) chk($sformatf("t2_gnt_spacing%0d", k), cg - prev_done, GAPC + 2);
            chk($sformatf("t2_ss_n%0d", k), bus.ss_n, exp_ssn[order[k]]);
            wait_done(60, dv, cd);
            chk($sformatf("t2_done%0d", k), dv, 4'b1 << order[k]);
            e16 = ~exp_cmd[order[k]];
            chk($sformatf("t2_rd%0d", k), bus.rd_data, e16);
            prev_done = cd;
        end
        bus.req = '0;
        wait_idle(20, ci);

        // 3. Invalid slave index on requester 1 (ptr now 1)
        set_req(1, 3'd7, 16'hDEAD);
        wc0 = wrt_cnt;
        dc0 = done_cnt;
        bus.req[1] = 1'b1;
        wait_gnt(5, idx, cg);
        chk("t3_gnt_idx", idx, 1);
        chk("t3_done", bus.done, 4'b0010);
        chk("t3_err", bus.err, 1);
        chk("t3_spi_wrt", bus.spi_wrt, 0);
        chk("t3_ss_n", bus.ss_n, 5'h1F);
        bus.req[1] = 1'b0;
        wait_idle(20, ci);
        chk("t3_gap_len", ci - cg, GAPC + 1);
        chk("t3_no_wrt", wrt_cnt - wc0, 0);
        chk("t3_one_done", done_cnt - dc0, 1);

        // 5. Request changed and dropped during WAIT (ptr now 2)
        set_req(0, 3'(SS_EEP), 16'hA55A);
        bus.req[0] = 1'b1;
        wait_gnt(5, idx, cg);
        chk("t5_gnt_idx", idx, 0);
        chk("t5_ss_n", bus.ss_n, 5'b01111);
        repeat (5) tick();
        set_req(0, 3'(SS_CH1), 16'hFFFF);
        bus.req[0] = 1'b0;
        repeat (3) tick();
        chk("t5_spi_cmd_frozen", bus.spi_cmd, 16'hA55A);
        chk("t5_ss_n_frozen", bus.ss_n, 5'b01111);
        chk("t5_busy", bus.busy, 1);
        wait_done(60, dv, cd);
        chk("t5_done", dv, 4'b0001);
        chk("t5_rd_data", bus.rd_data, 16'h5AA5);

        // 6. Stray spi_done in GAP and in IDLE
        tick();
        dc0 = done_cnt;
        inj_done = 1'b1;
        inj_rd   = 16'h1234;
        tick();
        inj_done = 1'b0;
        wait_idle(20, ci);
        chk("t6_gap_len", ci - cd, GAPC + 1);
        chk("t6_gap_no_done", done_cnt - dc0, 0);
        chk("t6_gap_rd_kept", bus.rd_data, 16'h5AA5);
        inj_done = 1'b1;
        inj_rd   = 16'h4321;
        tick();
        inj_done = 1'b0;
        repeat (2) tick();
        chk("t6_idle_busy", bus.busy, 0);
        chk("t6_idle_no_done", done_cnt - dc0, 0);
        chk("t6_idle_rd_kept", bus.rd_data, 16'h5AA5);

        // 4. Reset 10 cycles into WAIT (ptr now 1, grant to 2 moves it to 3)
        set_req(2, 3'(SS_CH2), 16'h0F0F);
        bus.req[2] = 1'b1;
        wait_gnt(5, idx, cg);
        chk("t4_gnt_idx", idx, 2);
        chk("t4_ss_n", bus.ss_n, 5'b11101);
        repeat (11) tick();
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("t4_rst_ss_n", bus.ss_n, 5'h1F);
        chk("t4_rst_busy", bus.busy, 0);
        bus.req[2] = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (45) tick();
        chk("t4_no_done", done_cnt - dc0, 0);
        set_req(3, 3'(SS_TRIG), 16'h7777);
        bus.req = 4'b1100;
        wait_gnt(5, idx, cg);
        chk("t4_ptr_reset_first", idx, 2);
        wait_done(60, dv, cd);
        chk("t4_done2", dv, 4'b0100);
        chk("t4_rd2", bus.rd_data, 16'hF0F0);
        bus.req[2] = 1'b0;
        wait_gnt(20, idx, cg);
        chk("t4_second", idx, 3);
        chk("t4_ss_n3", bus.ss_n, 5'b10111);
        wait_done(60, dv, cd);
        chk("t4_rd3", bus.rd_data, 16'h8888);
        bus.req = '0;
        wait_idle(20, ci);

        chk("ss_n_onehot", ss_viol, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
